// File: rtl/ren_recovery_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ren_recovery_ctrl: walks squashed ROB entries youngest-first, restoring  |
// | RAT mappings and freeing physregs. Optional: REN_RECOVERY_LOG_EN. Rev 1.0|
// +--------------------------------------------------------------------------+
module ren_recovery_ctrl #(
  parameter int PHYSREGS_DEPTH = 6,
  parameter int ROB_ADDRWIDTH  = 6,
  parameter     LOGGING_PREFIX = "RREC"
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        fROB_flushReq_IN,
  input  logic [ROB_ADDRWIDTH-1:0]    fROB_flushIdx_IN,
  input  logic [ROB_ADDRWIDTH-1:0]    fROB_curTail_IN,
  output logic [ROB_ADDRWIDTH-1:0]    tROB_probeIdx_OUT,
  input  logic [2*PHYSREGS_DEPTH+5:0] fROB_probeData_IN,
  output logic                        tROB_setTail_OUT,
  output logic [ROB_ADDRWIDTH-1:0]    tROB_newTail_OUT,
  output logic                        tRenRat_wrReq_OUT,
  output logic [4:0]                  tRenRat_wrIdx_OUT,
  output logic [PHYSREGS_DEPTH-1:0]   tRenRat_wrData_OUT,
  output logic                        tFreeL_pushReq_OUT,
  output logic [PHYSREGS_DEPTH-1:0]   tFreeL_pushData_OUT,
  input  logic                        fFreeL_full_IN,
  output logic                        tREN_freeze_OUT,
  output logic                        busy_OUT
);

  localparam int P = PHYSREGS_DEPTH;
  localparam logic [ROB_ADDRWIDTH-1:0] ROB_ONE = ROB_ADDRWIDTH'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd1;
  localparam logic [2:0] S_WALK  = 3'd2;
  localparam logic [2:0] S_STALL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]               state;
  logic [2:0]               next_state;
  logic [ROB_ADDRWIDTH-1:0] flush_idx;
  logic [ROB_ADDRWIDTH-1:0] ptr;
  logic [ROB_ADDRWIDTH-1:0] remaining;
  logic [ROB_ADDRWIDTH-1:0] drain_remaining;
  logic                     freeze;
  logic                     rat_req;
  logic [4:0]               rat_idx;
  logic [P-1:0]             rat_data;
  logic                     push_req;
  logic [P-1:0]             push_data;

  logic                     dest_reqd;
  logic [4:0]               arch_dest;
  logic [P-1:0]             new_phys;
  logic [P-1:0]             old_phys;
  logic                     walking;
  logic                     hold;
  logic                     step;

  assign dest_reqd = fROB_probeData_IN[2*P+5];
  assign arch_dest = fROB_probeData_IN[2*P+4:2*P];
  assign new_phys  = fROB_probeData_IN[2*P-1:P];
  assign old_phys  = fROB_probeData_IN[P-1:0];

  // STALL re-probes the same entry; once space frees up it undoes it directly.
  assign walking = (state == S_WALK) || (state == S_STALL);
  assign hold    = dest_reqd && fFreeL_full_IN;
  assign step    = walking && !hold;

  assign drain_remaining = fROB_curTail_IN - flush_idx - ROB_ONE;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (fROB_flushReq_IN) begin
          next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        next_state = (drain_remaining != '0) ? S_WALK : S_DONE;
      end
      S_WALK, S_STALL: begin
        if (hold) begin
          next_state = S_STALL;
        end else if (remaining == ROB_ONE) begin
          next_state = S_DONE;
        end else begin
          next_state = S_WALK;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tROB_probeIdx_OUT = '0;
    tROB_setTail_OUT  = 1'b0;
    tROB_newTail_OUT  = '0;
    busy_OUT          = (state != S_IDLE);
    if (walking) begin
      tROB_probeIdx_OUT = ptr;
    end
    if (state == S_DONE) begin
      tROB_setTail_OUT = 1'b1;
      tROB_newTail_OUT = flush_idx + ROB_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      flush_idx <= '0;
      ptr       <= '0;
      remaining <= '0;
      freeze    <= 1'b0;
      rat_req   <= 1'b0;
      rat_idx   <= '0;
      rat_data  <= '0;
      push_req  <= 1'b0;
      push_data <= '0;
    end else begin
      freeze   <= (next_state != S_IDLE);
      rat_req  <= step && dest_reqd;
      push_req <= step && dest_reqd;
      if ((state == S_IDLE) && fROB_flushReq_IN) begin
        flush_idx <= fROB_flushIdx_IN;
      end
      // curTail is sampled one cycle late so an in-flight rename push is included.
      if (state == S_DRAIN) begin
        ptr       <= fROB_curTail_IN - ROB_ONE;
        remaining <= drain_remaining;
      end else if (step) begin
        ptr       <= ptr - ROB_ONE;
        remaining <= remaining - ROB_ONE;
      end
      if (step && dest_reqd) begin
        rat_idx   <= arch_dest;
        rat_data  <= old_phys;
        push_data <= new_phys;
      end
    end
  end

  assign tREN_freeze_OUT     = freeze;
  assign tRenRat_wrReq_OUT   = rat_req;
  assign tRenRat_wrIdx_OUT   = rat_idx;
  assign tRenRat_wrData_OUT  = rat_data;
  assign tFreeL_pushReq_OUT  = push_req;
  assign tFreeL_pushData_OUT = push_data;

`ifdef REN_RECOVERY_LOG_EN
  always @(posedge CLK) begin
    if (RESET && step && dest_reqd) begin
      $display("[%s] undo rob=%0d arch=%0d rat<=%0d free=%0d",
               LOGGING_PREFIX, ptr, arch_dest, old_phys, new_phys);
    end
    if (RESET && (state == S_DONE)) begin
      $display("[%s] done newTail=%0d", LOGGING_PREFIX, tROB_newTail_OUT);
    end
  end
`else
  logic unused_prefix;
  assign unused_prefix = ^LOGGING_PREFIX;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ren_recovery_ctrl.sv
`default_nettype none
// tb_ren_recovery_ctrl: scoreboard bench; a ROB model feeds probe data and
// expected RAT/free-list writes and tail pulses are queued per flush.
module tb_ren_recovery_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_req;
  logic [5:0]  flush_idx;
  logic [5:0]  cur_tail;
  logic [5:0]  probe_idx;
  logic [17:0] probe_data;
  logic        set_tail;
  logic [5:0]  new_tail;
  logic        rat_wr_req;
  logic [4:0]  rat_wr_idx;
  logic [5:0]  rat_wr_data;
  logic        push_req;
  logic [5:0]  push_data;
  logic        fl_full;
  logic        freeze;
  logic        busy;

  logic [17:0] rob [0:63];
  logic [5:0]  rat_track [0:31];
  int          cyc = 0;
  int          flush_cycle = 0;
  int          n_checks = 0;
  int          n_bad = 0;

  typedef struct {
    bit         is_tail;
    logic [4:0] arch;
    logic [5:0] oldp;
    logic [5:0] newp;
    logic [5:0] tail;
    int         off;
  } ev_t;
  ev_t sb[$];
  ev_t mon_ev;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign probe_data = rob[probe_idx];

  ren_recovery_ctrl dut (
    .CLK                 (clk),
    .RESET               (rst_n),
    .fROB_flushReq_IN    (flush_req),
    .fROB_flushIdx_IN    (flush_idx),
    .fROB_curTail_IN     (cur_tail),
    .tROB_probeIdx_OUT   (probe_idx),
    .fROB_probeData_IN   (probe_data),
    .tROB_setTail_OUT    (set_tail),
    .tROB_newTail_OUT    (new_tail),
    .tRenRat_wrReq_OUT   (rat_wr_req),
    .tRenRat_wrIdx_OUT   (rat_wr_idx),
    .tRenRat_wrData_OUT  (rat_wr_data),
    .tFreeL_pushReq_OUT  (push_req),
    .tFreeL_pushData_OUT (push_data),
    .fFreeL_full_IN      (fl_full),
    .tREN_freeze_OUT     (freeze),
    .busy_OUT            (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [17:0] mk(input bit d, input int a, input int n, input int o);
    return {d, 5'(a), 6'(n), 6'(o)};
  endfunction

  // Output monitor: pops the scoreboard whenever the DUT emits a write or a tail pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rat_wr_req || push_req) begin
        check("wr_pair", push_req, rat_wr_req);
        if (sb.size() == 0 || sb[0].is_tail) begin
          check("unexpected_wr", 1, 0);
        end else begin
          mon_ev = sb.pop_front();
          check("wr_arch", rat_wr_idx, mon_ev.arch);
          check("wr_rat_data", rat_wr_data, mon_ev.oldp);
          check("wr_free_data", push_data, mon_ev.newp);
          check("wr_cycle", cyc - flush_cycle, mon_ev.off);
          rat_track[rat_wr_idx] = rat_wr_data;
        end
      end
      if (set_tail) begin
        if (sb.size() == 0 || !sb[0].is_tail) begin
          check("unexpected_tail", 1, 0);
        end else begin
          mon_ev = sb.pop_front();
          check("new_tail", new_tail, mon_ev.tail);
          check("tail_cycle", cyc - flush_cycle, mon_ev.off);
        end
      end
    end
  end

  task automatic do_flush(input logic [5:0] fi, input logic [5:0] ct, input int stall_at,
                          input int stall_len, input int reflush_at, input int abort_at);
    logic [5:0]  p;
    logic [5:0]  stall_ptr;
    logic [17:0] ent;
    ev_t         e;
    int          i;
    int          off;
    int          extra;
    int          tail_off;
    int          last_off;
    bit          exp_frz;
    bit          stalling;
    i     = 0;
    p     = ct - 6'd1;
    extra = (stall_at >= 0) ? stall_len : 0;
    while (p != fi) begin
      ent = rob[p];
      off = 3 + i + ((stall_at >= 0 && i >= stall_at) ? stall_len : 0);
      if (ent[17] && (abort_at < 0 || off < abort_at)) begin
        e.is_tail = 1'b0;
        e.arch    = ent[16:12];
        e.newp    = ent[11:6];
        e.oldp    = ent[5:0];
        e.tail    = '0;
        e.off     = off;
        sb.push_back(e);
      end
      i++;
      p = p - 6'd1;
    end
    tail_off = i + 2 + extra;
    if (abort_at < 0) begin
      e.is_tail = 1'b1;
      e.arch    = '0;
      e.newp    = '0;
      e.oldp    = '0;
      e.tail    = fi + 6'd1;
      e.off     = tail_off;
      sb.push_back(e);
    end
    stall_ptr = ct - 6'd1 - 6'((stall_at >= 0) ? stall_at : 0);
    last_off  = (abort_at >= 0) ? abort_at + 4 : tail_off + 2;
    for (int k = 0; k <= last_off; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) flush_cycle = cyc;
      flush_req = (k == 0) || (k == reflush_at);
      flush_idx = (k == 0) ? fi : fi + 6'd7;
      stalling  = (stall_at >= 0) && (k >= 2 + stall_at) && (k < 2 + stall_at + stall_len);
      fl_full   = stalling;
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_async_outs",
              {set_tail, new_tail, rat_wr_req, rat_wr_idx, rat_wr_data, push_req,
               push_data, probe_idx, freeze, busy}, 64'd0);
      end
      if (abort_at >= 0 && k == abort_at + 2) rst_n = 1'b1;
      @(negedge clk);
      exp_frz = (k >= 1) && (k <= tail_off) && (abort_at < 0 || k < abort_at);
      check("freeze", freeze, exp_frz);
      check("busy", busy, exp_frz);
      if (stall_at >= 0 && k >= 2 + stall_at && k <= 2 + stall_at + stall_len)
        check("probe_hold", probe_idx, stall_ptr);
    end
    flush_req = 1'b0;
    fl_full   = 1'b0;
    check("sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush_req = 1'b0;
    flush_idx = '0;
    cur_tail  = '0;
    fl_full   = 1'b0;
    for (int k = 0; k < 64; k++) rob[k] = '0;
    for (int k = 0; k < 32; k++) rat_track[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs",
          {set_tail, new_tail, rat_wr_req, rat_wr_idx, rat_wr_data, push_req,
           push_data, probe_idx, freeze, busy}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Empty flush
    cur_tail = 6'd6;
    do_flush(6'd5, 6'd6, -1, 0, -1, -1);

    // Three-entry walk, same arch written twice
    rob[5] = mk(1, 7, 40, 12);
    rob[4] = mk(1, 7, 33, 9);
    rob[3] = mk(1, 3, 50, 3);
    cur_tail = 6'd6;
    do_flush(6'd2, 6'd6, -1, 0, -1, -1);
    check("rat7_final", rat_track[7], 6'd9);
    check("rat3_final", rat_track[3], 6'd3);

    // Wrap-around through index 0 -> 63
    rob[0]  = mk(1, 4, 20, 21);
    rob[63] = mk(1, 5, 22, 23);
    cur_tail = 6'd1;
    do_flush(6'd62, 6'd1, -1, 0, -1, -1);

    // Free-list backpressure for 3 cycles on the first entry
    rob[12] = mk(1, 9, 44, 45);
    rob[11] = mk(1, 10, 46, 47);
    cur_tail = 6'd13;
    do_flush(6'd10, 6'd13, 0, 3, -1, -1);

    // destReqd=0 entry, archDest=0, second flush pulse ignored
    rob[23] = mk(1, 1, 30, 31);
    rob[22] = mk(0, 2, 34, 35);
    rob[21] = mk(1, 0, 32, 33);
    cur_tail = 6'd24;
    do_flush(6'd20, 6'd24, -1, 0, 3, -1);
    check("rat0_final", rat_track[0], 6'd33);

    // Asynchronous reset during the three-entry walk
    cur_tail = 6'd6;
    do_flush(6'd2, 6'd6, -1, 0, -1, 4);

    // Controller is usable again after the abandoned walk
    cur_tail = 6'd6;
    do_flush(6'd5, 6'd6, -1, 0, -1, -1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ren_recovery_ctrl.md
# ren_recovery_ctrl

Mispredict recovery sequencer for the rename stage. On a flush request from the ROB, it holds rename frozen and walks the squashed ROB entries from youngest to oldest. For each squashed entry that allocated a destination, it restores the rename-RAT mapping to the entry's previous physical register and returns the entry's allocated physical register to the free list. It then publishes the new ROB tail and releases rename.

## Interface
- `PHYSREGS_DEPTH`, 6: physical register index width.
- `ROB_ADDRWIDTH`, 6: ROB index width; ROB depth is 2^ROB_ADDRWIDTH.
- `LOGGING_PREFIX`, "RREC": prefix for log lines.
- `CLK` in 1: clock, rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `fROB_flushReq_IN` in 1: one-cycle pulse that starts recovery.
- `fROB_flushIdx_IN` in ROB_ADDRWIDTH: index of the youngest surviving entry (the mispredicted branch).
- `fROB_curTail_IN` in ROB_ADDRWIDTH: next free ROB slot.
- `tROB_probeIdx_OUT` out ROB_ADDRWIDTH: combinational ROB read index.
- `fROB_probeData_IN` in 6+2·PHYSREGS_DEPTH, read combinationally, fields:
  - [2P+5] destReqd
  - [2P+4:2P] archDest
  - [2P-1:P] newPhys
  - [P-1:0] oldPhys
- `tROB_setTail_OUT` out 1: one-cycle pulse; ROB tail is set to `tROB_newTail_OUT`.
- `tROB_newTail_OUT` out ROB_ADDRWIDTH: flushIdx+1 (mod depth).
- `tRenRat_wrReq_OUT` out 1: rename-RAT single-entry write enable.
- `tRenRat_wrIdx_OUT` out 5: architectural index for the RAT write.
- `tRenRat_wrData_OUT` out PHYSREGS_DEPTH: restored physical register.
- `tFreeL_pushReq_OUT` out 1: free-list push.
- `tFreeL_pushData_OUT` out PHYSREGS_DEPTH: physical register returned to the free list.
- `fFreeL_full_IN` in 1: free list full.
- `tREN_freeze_OUT` out 1: FREEZE to rename, Q_IDREN and ROB push.
- `busy_OUT` out 1: high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: wait for a flush.
  - DRAIN: one cycle; lets the in-flight rename push land in the ROB.
  - WALK: undo one entry per cycle.
  - STALL: wait for free-list space.
  - DONE: one cycle; publish the new tail.
- IDLE, `fROB_flushReq_IN`=1:
  - Latch `flushIdx`.
  - Go to DRAIN.
- DRAIN:
  - Latch `ptr` = curTail−1 and `remaining` = (curTail − flushIdx − 1) mod 2^ROB_ADDRWIDTH.
  - Go to WALK if remaining≠0, else DONE.
- WALK, each cycle:
  - `tROB_probeIdx_OUT`=ptr.
  - If destReqd && fFreeL_full_IN: go to STALL with no writes and no advance.
  - Otherwise, if destReqd: register RAT write (archDest ← oldPhys) and free-list push (newPhys).
  - Then ptr−1 (wraps 0→2^W−1) and remaining−1.
  - At remaining==1 (last entry consumed), go to DONE.
- STALL:
  - Probe stays at ptr.
  - Return to WALK the first cycle fFreeL_full_IN=0.
- DONE:
  - `tROB_setTail_OUT`=1 and `tROB_newTail_OUT`=flushIdx+1.
  - Go to IDLE.
- Entries are undone youngest-first, so the final RAT value for each arch register is the oldPhys of its oldest squashed writer.
- Entries with destReqd=0 consume one cycle and produce no writes.
- archDest=0 is treated like any other index; there is no special case.
- `fROB_flushReq_IN` while busy is ignored. The ROB must not issue a second flush until busy_OUT falls.
- Index arithmetic is modulo 2^ROB_ADDRWIDTH. flushIdx==curTail−1 means nothing to undo.

## Timing
- Reset (RESET low, asynchronous):
  - State = IDLE.
  - All outputs 0, including the freeze and probe index.
  - Reset taken mid-walk abandons the walk; no further writes or pulses occur.
- `tREN_freeze_OUT` is registered:
  - Rises the cycle after the flush pulse (entering DRAIN).
  - Falls the cycle after DONE.
- RAT write and free-list push are registered. They appear one cycle after the WALK cycle that probed the entry, last for one cycle, and the two requests are simultaneous.
- Total latency with N squashed entries and no stalls is N+2 cycles from the flush pulse to `tROB_setTail_OUT`, plus one cycle per STALL cycle.
- Free-list full is sampled in the probing cycle. The free list never overflows because the number of pushes never exceeds the registers allocated.

## Configuration
- `REN_RECOVERY_LOG_EN` defined: one display line per undone entry, formatted as `[LOGGING_PREFIX] undo rob=<ptr> arch=<a> rat<=<old> free=<new>`, plus one line at DONE with the new tail.
- Not defined: no display statements are compiled.
- Functional behaviour is identical either way.

## Test plan
- **Empty flush:** flushIdx=5, curTail=6 -> freeze high 2 cycles; setTail pulse with newTail=6 two cycles after the flush; no RAT or free-list writes.
- **Three-entry walk:** flushIdx=2, curTail=6; entries 5, 4 and 3 are (arch 7, new 40, old 12), (arch 7, new 33, old 9), (arch 3, new 50, old 3) -> writes in order: RAT[7]←12/free 40, RAT[7]←9/free 33, RAT[3]←3/free 50; final RAT[7]=9; setTail with newTail=3 at cycle 5.
- **Wrap-around:** flushIdx=62, curTail=1; entries 0 and 63 have destReqd=1 -> probes 0 then 63; two pushes; newTail=63.
- **Backpressure:** fFreeL_full_IN high for 3 cycles while the probe points at a destReqd entry -> no write during the stall; ptr held; write occurs after full drops; latency +3.
- **destReqd=0 entry:** entry is skipped with no write but consumes a cycle -> a second flush pulse during the walk is ignored and busy_OUT stays high until DONE.
- **Async reset mid-walk:** assert RESET low mid-walk -> all outputs 0 immediately; IDLE after release; no setTail pulse.
